alu_op_sequencer: RTL

- Issue/writeback stage wrapped around the existing 8-bit signed ALU.
- Accepts register-based instructions over a valid/ready handshake and holds a small register file.
- Drives the ALU operand and select inputs (A, B, ALU_Sel), then captures ALU_Out back into the register file.
- The ALU is instantiated outside this block; this block is its direct upstream feeder and downstream consumer.

---
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/writeback stage feeding an external signed ALU.
// Ports: clk, reset (sync, active-high); instr_* valid/ready instruction
//   input (load-immediate or ALU op on register indices); A/B/ALU_Sel
//   registered ALU drive; ALU_Out combinational ALU result; done one-cycle
//   retire pulse; busy high in ISSUE/WB.
// Optional: define ALU_SEQ_ZERO_FLAG_EN to add registered output zero_flag.
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             instr_load,
  input  logic [1:0]       instr_sel,
  input  logic [AW-1:0]    instr_dst,
  input  logic [AW-1:0]    instr_srca,
  input  logic [AW-1:0]    instr_srcb,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       ALU_Sel,
  input  logic [WIDTH-1:0] ALU_Out,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic             zero_flag,
`endif
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_rf [NREGS];
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_sel;
  logic [AW-1:0]    r_dst;
  logic             r_done;

  logic w_ready;
  logic w_busy;
  logic w_accept;

  // Ready is a pure function of state.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (instr_valid && !instr_load)
          w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_busy = 1'b1;
        w_next = S_WB;
      end
      S_WB: begin
        w_busy = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = instr_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Loads retire at the accept edge; ALU ops write back when leaving ISSUE.
  // done is registered so it appears in the cycle after either write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        r_rf[i] <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sel  <= '0;
      r_dst  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (instr_load) begin
          r_rf[instr_dst] <= instr_imm;
          r_done          <= 1'b1;
        end else begin
          r_a   <= r_rf[instr_srca];
          r_b   <= r_rf[instr_srcb];
          r_sel <= instr_sel;
          r_dst <= instr_dst;
        end
      end
      if (r_state == S_ISSUE) begin
        r_rf[r_dst] <= ALU_Out;
        r_done      <= 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (reset)
      r_zero <= 1'b0;
    else if (r_state == S_ISSUE)
      r_zero <= (ALU_Out == '0);
    else if (w_accept && instr_load)
      r_zero <= (instr_imm == '0);
  end

  assign zero_flag = r_zero;
`endif

  assign instr_ready = w_ready;
  assign busy        = w_busy;
  assign done        = r_done;
  assign A           = r_a;
  assign B           = r_b;
  assign ALU_Sel     = r_sel;

endmodule
